// File: rtl/mbist_pkg.sv
// Shared definitions for the MBIST memory responder: bank encodings,
// the fault-table entry layout, the FSM state type and the per-entry overlay.
package mbist_pkg;

    localparam int DEFAULT_NUM_FAULTS = 8;

    // One-hot bank selects; any other pattern is an invalid access.
    localparam logic [1:0] BANK0 = 2'b01;
    localparam logic [1:0] BANK1 = 2'b10;

    typedef struct packed {
        logic       en;
        logic [1:0] bank;
        logic [9:0] row;
        logic [9:0] col;
        logic [7:0] mask;
        logic [7:0] val;
    } fault_entry_t;

    typedef enum logic {
        ST_CLEAR,
        ST_READY
    } state_t;

    // Replace the masked bits of data with the stuck values.
    function automatic logic [7:0] apply_fault(input logic [7:0] data,
                                               input logic [7:0] mask,
                                               input logic [7:0] val);
        return (data & ~mask) | (val & mask);
    endfunction

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] cnt, input logic en);
        return (en && (cnt != 32'hFFFF_FFFF)) ? cnt + 32'd1 : cnt;
    endfunction

endpackage

// File: rtl/mbist_fault_cam.sv
// Fault table: one write port, plus a purely combinational lookup that
// matches every entry in parallel and overlays the stuck bits onto the
// background value. Later (higher-index) entries override earlier ones per bit.
module mbist_fault_cam
    import mbist_pkg::*;
#(
    parameter int NUM_FAULTS = DEFAULT_NUM_FAULTS
) (
    input  logic                          clk,
    input  logic                          wr_en,
    input  logic [$clog2(NUM_FAULTS)-1:0] wr_idx,
    input  fault_entry_t                  wr_entry,
    input  logic [1:0]                    lk_bank,
    input  logic [9:0]                    lk_row,
    input  logic [9:0]                    lk_col,
    input  logic [7:0]                    lk_data,
    output logic [7:0]                    ovl_data
);

    fault_entry_t entries [NUM_FAULTS];

    // Table write; the new entry is visible to lookups from the next cycle.
    // NOTE: the table has no reset -- the owner's CLEAR sweep zeroes it one
    // entry per cycle, which keeps this a plain RAM-style array. Non-blocking
    // assignment here so a same-cycle lookup still reads the old entry.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            entries[wr_idx] <= wr_entry;
        end
    end

    // Parallel match; iterating upward lets the highest matching index win.
    // NOTE: ovl_data gets its default before the loop so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        ovl_data = lk_data;
        for (int i = 0; i < NUM_FAULTS; i++) begin
            if (entries[i].en && (entries[i].bank == lk_bank) &&
                (entries[i].row == lk_row) && (entries[i].col == lk_col)) begin
                ovl_data = apply_fault(ovl_data, entries[i].mask, entries[i].val);
            end
        end
    end

endmodule

// File: rtl/mbist_mem_responder.sv
// Behavioural memory stand-in for MBIST: two background registers, a
// programmable stuck-bit fault table, a read pipeline of RD_LAT stages,
// saturating access counters and an invalid-bank error pulse.
module mbist_mem_responder
    import mbist_pkg::*;
#(
    parameter int NUM_FAULTS = DEFAULT_NUM_FAULTS,
    parameter int RD_LAT     = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ce,
    input  logic                          we,
    input  logic [9:0]                    row_addr,
    input  logic [9:0]                    col_addr,
    input  logic [1:0]                    bank_addr,
    input  logic [7:0]                    data_w,
    output logic [7:0]                    data_r,
    input  logic                          cfg_we,
    input  logic [$clog2(NUM_FAULTS)-1:0] cfg_idx,
    input  logic                          cfg_en,
    input  logic [1:0]                    cfg_bank,
    input  logic [9:0]                    cfg_row,
    input  logic [9:0]                    cfg_col,
    input  logic [7:0]                    cfg_mask,
    input  logic [7:0]                    cfg_val,
    output logic                          ready,
    output logic                          bank_err,
    output logic [31:0]                   wr_cnt,
    output logic [31:0]                   rd_cnt,
    output logic [31:0]                   hit_cnt
);

    localparam int IDX_W = $clog2(NUM_FAULTS);

    state_t            state, state_nxt;
    logic [IDX_W-1:0]  clr_idx, clr_idx_nxt;
    logic              cam_we;
    logic [IDX_W-1:0]  cam_idx;
    fault_entry_t      cam_entry;

    logic       bank_ok, acc_wr, acc_rd, acc_bad, rd_any, hit;
    logic [7:0] bg0, bg1, bg_sel, ovl_data, rd_word;

    logic       pipe_vld [RD_LAT];
    logic [7:0] pipe_dat [RD_LAT];

    // Access decode: nothing is serviced until the table sweep has finished.
    assign ready   = (state == ST_READY);
    assign bank_ok = (bank_addr == BANK0) || (bank_addr == BANK1);
    assign acc_wr  = ready && ce && we  && bank_ok;
    assign acc_rd  = ready && ce && !we && bank_ok;
    assign acc_bad = ready && ce && !bank_ok;
    assign rd_any  = ready && ce && !we;
    assign bg_sel  = (bank_addr == BANK1) ? bg1 : bg0;
    assign rd_word = bank_ok ? ovl_data : 8'h00;
    assign hit     = acc_rd && (ovl_data != bg_sel);
    assign data_r  = pipe_dat[RD_LAT-1];

    mbist_fault_cam #(
        .NUM_FAULTS (NUM_FAULTS)
    ) u_cam (
        .clk      (clk),
        .wr_en    (cam_we),
        .wr_idx   (cam_idx),
        .wr_entry (cam_entry),
        .lk_bank  (bank_addr),
        .lk_row   (row_addr),
        .lk_col   (col_addr),
        .lk_data  (bg_sel),
        .ovl_data (ovl_data)
    );

    // FSM state and clear-sweep index.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_CLEAR;
            clr_idx <= '0;
        end else begin
            state   <= state_nxt;
            clr_idx <= clr_idx_nxt;
        end
    end

    // Next state and table write-port steering: CLEAR owns the port, READY
    // hands it to the configuration interface.
    always_comb begin
        state_nxt   = state;
        clr_idx_nxt = clr_idx;
        cam_we      = 1'b0;
        cam_idx     = cfg_idx;
        cam_entry   = '{en: cfg_en, bank: cfg_bank, row: cfg_row, col: cfg_col,
                        mask: cfg_mask, val: cfg_val};
        unique case (state)
            ST_CLEAR: begin
                cam_we      = 1'b1;
                cam_idx     = clr_idx;
                cam_entry   = '0;
                clr_idx_nxt = clr_idx + 1'b1;
                if (clr_idx == IDX_W'(NUM_FAULTS - 1)) begin
                    state_nxt = ST_READY;
                end
            end
            ST_READY: begin
                cam_we = cfg_we;
            end
            default: begin
                state_nxt = ST_CLEAR;
            end
        endcase
    end

    // Background registers; faults never touch these, they only overlay reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            bg0 <= 8'h00;
            bg1 <= 8'h00;
        end else if (acc_wr) begin
            if (bank_addr == BANK1) bg1 <= data_w;
            else                    bg0 <= data_w;
        end
    end

    // Read pipeline; each stage only loads when its input is valid, so the
    // last stage doubles as the holding register behind data_r.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_vld[i] <= 1'b0;
                pipe_dat[i] <= 8'h00;
            end
        end else begin
            pipe_vld[0] <= rd_any;
            if (rd_any) pipe_dat[0] <= rd_word;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                if (pipe_vld[i-1]) pipe_dat[i] <= pipe_dat[i-1];
            end
        end
    end

    // Saturating counters and the invalid-bank pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt   <= 32'd0;
            rd_cnt   <= 32'd0;
            hit_cnt  <= 32'd0;
            bank_err <= 1'b0;
        end else begin
            wr_cnt   <= sat_inc(wr_cnt, acc_wr);
            rd_cnt   <= sat_inc(rd_cnt, acc_rd);
            hit_cnt  <= sat_inc(hit_cnt, hit);
            bank_err <= acc_bad;
        end
    end

endmodule

// File: tb/tb_mbist_mem_responder.sv
// Self-checking bench for mbist_mem_responder (defaults: 8 entries, RD_LAT 1).
// Expected read data is pushed to a scoreboard queue as each read is driven
// and popped when data_r is due; counters are tracked by a small model.
module tb_mbist_mem_responder;

    localparam int NF    = 8;
    localparam int IDX_W = $clog2(NF);

    logic             clk = 1'b0;
    logic             rst, ce, we, cfg_we, cfg_en;
    logic [9:0]       row_addr, col_addr, cfg_row, cfg_col;
    logic [1:0]       bank_addr, cfg_bank;
    logic [7:0]       data_w, data_r, cfg_mask, cfg_val;
    logic [IDX_W-1:0] cfg_idx;
    logic             ready, bank_err;
    logic [31:0]      wr_cnt, rd_cnt, hit_cnt;

    mbist_mem_responder #(
        .NUM_FAULTS (NF),
        .RD_LAT     (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ce        (ce),
        .we        (we),
        .row_addr  (row_addr),
        .col_addr  (col_addr),
        .bank_addr (bank_addr),
        .data_w    (data_w),
        .data_r    (data_r),
        .cfg_we    (cfg_we),
        .cfg_idx   (cfg_idx),
        .cfg_en    (cfg_en),
        .cfg_bank  (cfg_bank),
        .cfg_row   (cfg_row),
        .cfg_col   (cfg_col),
        .cfg_mask  (cfg_mask),
        .cfg_val   (cfg_val),
        .ready     (ready),
        .bank_err  (bank_err),
        .wr_cnt    (wr_cnt),
        .rd_cnt    (rd_cnt),
        .hit_cnt   (hit_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       wr;
        logic [1:0] bank;
        logic [9:0] row;
        logic [9:0] col;
        logic [7:0] data;
        logic [7:0] exp;
        bit         hit;
    } vec_t;

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] exp_q [$];
    bit         rd_pend  = 1'b0;
    bit         err_pend = 1'b0;
    logic [7:0] last_rd  = 8'h00;
    int         exp_wr = 0, exp_rd = 0, exp_hit = 0;
    vec_t       vecs [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One clock; compare data_r against the scoreboard (or its held value)
    // and bank_err against the pulse predicted by the previous drive.
    task automatic tick();
        @(posedge clk);
        #1;
        if (rd_pend) begin
            last_rd = exp_q.pop_front();
            check("data_r", {24'd0, data_r}, {24'd0, last_rd});
        end else begin
            check("data_r_hold", {24'd0, data_r}, {24'd0, last_rd});
        end
        check("bank_err", {31'd0, bank_err}, {31'd0, err_pend});
        rd_pend  = 1'b0;
        err_pend = 1'b0;
        ce       = 1'b0;
        we       = 1'b0;
        cfg_we   = 1'b0;
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_wr_cnt"},  wr_cnt,  exp_wr);
        check({tag, "_rd_cnt"},  rd_cnt,  exp_rd);
        check({tag, "_hit_cnt"}, hit_cnt, exp_hit);
    endtask

    // Drive one access for the coming edge; does not advance time.
    task automatic issue(input logic w, input logic [1:0] b, input logic [9:0] r,
                         input logic [9:0] c, input logic [7:0] d,
                         input logic [7:0] e, input bit h);
        bit valid;
        valid     = (b == 2'b01) || (b == 2'b10);
        ce        = 1'b1;
        we        = w;
        bank_addr = b;
        row_addr  = r;
        col_addr  = c;
        data_w    = d;
        err_pend  = !valid;
        if (!w) begin
            exp_q.push_back(e);
            rd_pend = 1'b1;
            if (valid) exp_rd++;
            if (h) exp_hit++;
        end else if (valid) begin
            exp_wr++;
        end
    endtask

    task automatic drive_cfg(input logic [IDX_W-1:0] idx, input logic en, input logic [1:0] b,
                             input logic [9:0] r, input logic [9:0] c,
                             input logic [7:0] m, input logic [7:0] v);
        cfg_we   = 1'b1;
        cfg_idx  = idx;
        cfg_en   = en;
        cfg_bank = b;
        cfg_row  = r;
        cfg_col  = c;
        cfg_mask = m;
        cfg_val  = v;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        exp_q.delete();
        rd_pend  = 1'b0;
        err_pend = 1'b0;
        last_rd  = 8'h00;
        exp_wr   = 0;
        exp_rd   = 0;
        exp_hit  = 0;
        tick();
        check("rst_ready", {31'd0, ready}, 32'd0);
        check_counts("rst");
        rst = 1'b0;
    endtask

    // Count cycles until ready; optionally keep hammering accesses and cfg
    // writes during CLEAR, which must all be ignored.
    task automatic wait_ready(input bit poke);
        bit got;
        got = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            if (poke) begin
                ce = 1'b1; we = 1'b1; bank_addr = 2'b01;
                row_addr = 10'd0; col_addr = 10'd0; data_w = 8'hAA;
                drive_cfg(3'd2, 1'b1, 2'b01, 10'd0, 10'd0, 8'hFF, 8'h5A);
            end
            tick();
            if (ready) begin
                check("ready_latency", n, NF);
                got = 1'b1;
                break;
            end
        end
        if (!got) check("ready_timeout", {31'd0, ready}, 32'd1);
    endtask

    initial begin
        rst = 1'b1; ce = 1'b0; we = 1'b0; cfg_we = 1'b0; cfg_en = 1'b0;
        row_addr = '0; col_addr = '0; bank_addr = 2'b01; data_w = '0;
        cfg_idx = '0; cfg_bank = '0; cfg_row = '0; cfg_col = '0;
        cfg_mask = '0; cfg_val = '0;

        do_reset();
        wait_ready(1'b1);
        check_counts("clear_ignored");

        // Plain write/read, no faults.
        issue(1'b1, 2'b01, 10'd5, 10'd8, 8'h00, 8'h00, 1'b0); tick();
        issue(1'b0, 2'b01, 10'd5, 10'd8, 8'h00, 8'h00, 1'b0); tick();
        check_counts("basic");
        // The cfg write attempted during CLEAR must not have landed.
        issue(1'b0, 2'b01, 10'd0, 10'd0, 8'h00, 8'h00, 1'b0); tick();

        // Fault entries; 1 and 6 collide on bit 0 of the same cell.
        drive_cfg(3'd0, 1'b1, 2'b01, 10'd3, 10'd16, 8'h81, 8'hFF); tick();
        drive_cfg(3'd1, 1'b1, 2'b01, 10'd7, 10'd7,  8'h01, 8'h00); tick();
        drive_cfg(3'd6, 1'b1, 2'b01, 10'd7, 10'd7,  8'h01, 8'h01); tick();
        drive_cfg(3'd3, 1'b1, 2'b10, 10'd1, 10'd2,  8'hF0, 8'hA0); tick();

        vecs[0]  = '{1'b0, 2'b01, 10'd3,  10'd16, 8'h00, 8'h81, 1'b1};
        vecs[1]  = '{1'b0, 2'b01, 10'd4,  10'd16, 8'h00, 8'h00, 1'b0};
        vecs[2]  = '{1'b0, 2'b01, 10'd7,  10'd7,  8'h00, 8'h01, 1'b1};
        vecs[3]  = '{1'b1, 2'b01, 10'd3,  10'd16, 8'h3C, 8'h00, 1'b0};
        vecs[4]  = '{1'b0, 2'b01, 10'd3,  10'd16, 8'h00, 8'hBD, 1'b1};
        vecs[5]  = '{1'b0, 2'b01, 10'd9,  10'd9,  8'h00, 8'h3C, 1'b0};
        vecs[6]  = '{1'b0, 2'b01, 10'd7,  10'd7,  8'h00, 8'h3D, 1'b1};
        vecs[7]  = '{1'b1, 2'b10, 10'd0,  10'd0,  8'h5F, 8'h00, 1'b0};
        vecs[8]  = '{1'b0, 2'b10, 10'd1,  10'd2,  8'h00, 8'hAF, 1'b1};
        vecs[9]  = '{1'b0, 2'b10, 10'd3,  10'd16, 8'h00, 8'h5F, 1'b0};
        vecs[10] = '{1'b0, 2'b11, 10'd3,  10'd16, 8'h00, 8'h00, 1'b0};
        vecs[11] = '{1'b1, 2'b00, 10'd0,  10'd0,  8'hFF, 8'h00, 1'b0};
        vecs[12] = '{1'b0, 2'b01, 10'd0,  10'd0,  8'h00, 8'h3C, 1'b0};
        vecs[13] = '{1'b1, 2'b10, 10'd0,  10'd0,  8'hA5, 8'h00, 1'b0};
        vecs[14] = '{1'b0, 2'b10, 10'd1,  10'd2,  8'h00, 8'hA5, 1'b0};
        vecs[15] = '{1'b0, 2'b10, 10'd0,  10'd0,  8'h00, 8'hA5, 1'b0};

        for (int i = 0; i < 16; i++) begin
            issue(vecs[i].wr, vecs[i].bank, vecs[i].row, vecs[i].col,
                  vecs[i].data, vecs[i].exp, vecs[i].hit);
            tick();
            if (i == 10) check_counts("bad_bank_read");
        end
        check_counts("table");

        // Table update and read of the same cell in one cycle: old entry first.
        drive_cfg(3'd2, 1'b1, 2'b01, 10'd9, 10'd9, 8'hFF, 8'h77);
        issue(1'b0, 2'b01, 10'd9, 10'd9, 8'h00, 8'h3C, 1'b0); tick();
        issue(1'b0, 2'b01, 10'd9, 10'd9, 8'h00, 8'h77, 1'b1); tick();
        check_counts("cfg_same_cycle");

        // Reset landing on a read: nothing from that read may appear.
        issue(1'b0, 2'b01, 10'd3, 10'd16, 8'h00, 8'hBD, 1'b1);
        do_reset();
        wait_ready(1'b0);
        issue(1'b0, 2'b01, 10'd3, 10'd16, 8'h00, 8'h00, 1'b0); tick();
        check_counts("after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
